// File: rtl/xgemac_pkg.sv
// xgemac_pkg: shared widths, rx FSM states, rx beat record and byte-count helper for the XGEMAC packet interface
package xgemac_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int MOD_WIDTH  = 3;
  typedef enum logic {IDLE, READ} rx_state_e;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sop;
    logic                  eop;
    logic [MOD_WIDTH-1:0]  mod;
    logic                  err;
  } rx_beat_t;
  function automatic logic [3:0] beat_bytes(input logic eop, input logic [MOD_WIDTH-1:0] mod);
    return (eop && mod != '0) ? 4'(mod) : 4'd8;
  endfunction
endpackage

// File: rtl/xgemac_rx_skid_fifo.sv
// xgemac_rx_skid_fifo: first-word fall-through FIFO of rx beats
// Ports: clk, rst_n (async active-low); push_i/din_i write side; pop_i read side,
// dout_o is the head entry; count_o fill level; full_o/empty_o status.
import xgemac_pkg::*;
module xgemac_rx_skid_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  rx_beat_t                 din_i,
  input  logic                     pop_i,
  output rx_beat_t                 dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  rx_beat_t       mem_q [DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [AW:0]    cnt_q;
  logic           do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  // a pop frees the slot in the same edge, so push into a full FIFO is fine then
  assign do_push = push_i & (~full_o | do_pop);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/xgemac_rx_pkt_reader.sv
// xgemac_rx_pkt_reader: reads frames from the XGEMAC rx packet interface into a valid/ready stream with statistics
// Ports: clk, rst_n (async active-low); pkt_rx_* MAC read interface (ren out, beats back one cycle later);
// out_* / out_rdy downstream stream; frame_cnt, byte_cnt, err_cnt, proto_err_cnt, last_frame_len statistics.
import xgemac_pkg::*;
module xgemac_rx_pkt_reader #(
  parameter int DATA_WIDTH = xgemac_pkg::DATA_WIDTH,
  parameter int MOD_WIDTH  = xgemac_pkg::MOD_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  pkt_rx_ren,
  input  logic                  pkt_rx_avail,
  input  logic [DATA_WIDTH-1:0] pkt_rx_data,
  input  logic                  pkt_rx_val,
  input  logic                  pkt_rx_sop,
  input  logic                  pkt_rx_eop,
  input  logic [MOD_WIDTH-1:0]  pkt_rx_mod,
  input  logic                  pkt_rx_err,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_val,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  out_err,
  output logic [MOD_WIDTH-1:0]  out_mod,
  input  logic                  out_rdy,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  byte_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [CNT_WIDTH-1:0]  proto_err_cnt,
  output logic [15:0]           last_frame_len
);
  rx_state_e                    state_q, state_d;
  logic                         ren_q, in_frame_q, in_frame_d;
  logic [15:0]                  len_q, len_d, last_len_q, last_len_d;
  logic [CNT_WIDTH-1:0]         frame_q, frame_d, byte_q, byte_d, err_q, err_d, proto_q, proto_d;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         fifo_full, fifo_empty, accept, last, first, proto, pop;
  logic [3:0]                   bytes;
  logic [16:0]                  len_sum;
  logic [15:0]                  len_sat;
  rx_beat_t                     push_beat, head;
  assign accept = pkt_rx_val & ren_q;
  assign last   = accept & pkt_rx_eop;
  assign first  = ~in_frame_q;
  // stray beats, a missing sop and a sop inside a frame are mutually exclusive, so at most +1 per cycle
  assign proto  = (pkt_rx_val & ~ren_q) | (accept & (first ? ~pkt_rx_sop : pkt_rx_sop));
  assign bytes  = beat_bytes(pkt_rx_eop, pkt_rx_mod);
  // a sop always restarts the length, dropping any unfinished frame
  assign len_sum = ((first | pkt_rx_sop) ? 17'd0 : {1'b0, len_q}) + 17'(bytes);
  assign len_sat = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  // never read in the eop cycle so the MAC cannot roll into the next frame early
  assign pkt_rx_ren = (state_q == READ) && (32'(fifo_count) + 32'(ren_q) < FIFO_DEPTH)
                      && !(pkt_rx_val && pkt_rx_eop);
  assign push_beat = '{data: pkt_rx_data, sop: pkt_rx_sop | first, eop: pkt_rx_eop,
                       mod: pkt_rx_mod, err: pkt_rx_err};
  assign pop      = out_val & out_rdy;
  assign out_val  = ~fifo_empty;
  assign out_data = head.data;
  assign out_sop  = head.sop;
  assign out_eop  = head.eop;
  assign out_mod  = head.mod;
  assign out_err  = head.err;
  assign frame_cnt      = frame_q;
  assign byte_cnt       = byte_q;
  assign err_cnt        = err_q;
  assign proto_err_cnt  = proto_q;
  assign last_frame_len = last_len_q;
  always_comb begin
    state_d    = (state_q == IDLE) ? (pkt_rx_avail ? READ : IDLE) : (last ? IDLE : READ);
    in_frame_d = accept ? ~pkt_rx_eop : in_frame_q;
    len_d      = accept ? (pkt_rx_eop ? 16'd0 : len_sat) : len_q;
    last_len_d = last ? len_sat : last_len_q;
    frame_d    = frame_q + CNT_WIDTH'(last);
    err_d      = err_q + CNT_WIDTH'(last & pkt_rx_err);
    byte_d     = byte_q + (accept ? CNT_WIDTH'(bytes) : '0);
    proto_d    = proto_q + CNT_WIDTH'(proto);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ren_q      <= 1'b0;
      in_frame_q <= 1'b0;
      len_q      <= '0;
      last_len_q <= '0;
      frame_q    <= '0;
      byte_q     <= '0;
      err_q      <= '0;
      proto_q    <= '0;
    end else begin
      state_q    <= state_d;
      ren_q      <= pkt_rx_ren;
      in_frame_q <= in_frame_d;
      len_q      <= len_d;
      last_len_q <= last_len_d;
      frame_q    <= frame_d;
      byte_q     <= byte_d;
      err_q      <= err_d;
      proto_q    <= proto_d;
    end
  end
  xgemac_rx_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept & (~fifo_full | pop)),
    .din_i   (push_beat),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
endmodule

// File: tb/tb_xgemac_rx_pkt_reader.sv
// tb_xgemac_rx_pkt_reader: randomized and directed self-checking bench with a MAC model and frame-level scoreboard
import xgemac_pkg::*;
module tb_xgemac_rx_pkt_reader;
  logic        clk = 0, rst_n = 0;
  logic        pkt_rx_ren, pkt_rx_avail = 0, pkt_rx_val = 0, pkt_rx_sop = 0, pkt_rx_eop = 0, pkt_rx_err = 0;
  logic [63:0] pkt_rx_data = '0, out_data;
  logic [2:0]  pkt_rx_mod = '0, out_mod;
  logic        out_val, out_sop, out_eop, out_err, out_rdy = 1;
  logic [31:0] frame_cnt, byte_cnt, err_cnt, proto_err_cnt;
  logic [15:0] last_frame_len;
  int checks = 0, failures = 0;
  rx_beat_t mac_q[$], exp_q[$];
  logic ren_prev = 0, stray_req = 0, in_frame = 0, rand_rdy = 0;
  int pushed = 0, pops = 0;
  longint e_frames = 0, e_bytes = 0, e_err = 0, e_proto = 0, e_last = 0;
  always #5 clk = ~clk;
  xgemac_rx_pkt_reader dut (
    .clk(clk), .rst_n(rst_n), .pkt_rx_ren(pkt_rx_ren), .pkt_rx_avail(pkt_rx_avail),
    .pkt_rx_data(pkt_rx_data), .pkt_rx_val(pkt_rx_val), .pkt_rx_sop(pkt_rx_sop),
    .pkt_rx_eop(pkt_rx_eop), .pkt_rx_mod(pkt_rx_mod), .pkt_rx_err(pkt_rx_err),
    .out_data(out_data), .out_val(out_val), .out_sop(out_sop), .out_eop(out_eop),
    .out_err(out_err), .out_mod(out_mod), .out_rdy(out_rdy), .frame_cnt(frame_cnt),
    .byte_cnt(byte_cnt), .err_cnt(err_cnt), .proto_err_cnt(proto_err_cnt),
    .last_frame_len(last_frame_len));
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic add_frame(input int n, input int m, input bit err, input bit sop0);
    rx_beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = {$urandom, $urandom};
      b.sop  = (i == 0) && sop0;
      b.eop  = i == n - 1;
      b.mod  = b.eop ? 3'(m) : 3'd0;
      b.err  = b.eop && err;
      mac_q.push_back(b);
    end
    e_frames++;
    e_last = 8 * (n - 1) + (m % 8 != 0 ? m % 8 : 8);
    e_bytes += e_last;
    e_err += err;
    if (!sop0) e_proto++;
  endtask
  task automatic add_partial(input int n);
    rx_beat_t b;
    for (int i = 0; i < n; i++) begin
      b = '{data: {$urandom, $urandom}, sop: i == 0, eop: 1'b0, mod: 3'd0, err: 1'b0};
      mac_q.push_back(b);
    end
    e_bytes += 8 * n;
    e_proto++;
  endtask
  task automatic step();
    rx_beat_t b, h;
    int occ;
    if (ren_prev && mac_q.size() != 0) begin
      b = mac_q.pop_front();
      {pkt_rx_data, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, pkt_rx_err} = b;
      pkt_rx_val = 1;
    end else if (stray_req) begin
      pkt_rx_data = {$urandom, $urandom}; pkt_rx_sop = 0; pkt_rx_eop = 0; pkt_rx_mod = 0; pkt_rx_err = 0;
      pkt_rx_val = 1;
      stray_req = 0;
    end else pkt_rx_val = 0;
    pkt_rx_avail = mac_q.size() != 0;
    if (rand_rdy) out_rdy = $urandom_range(0, 1) == 1;
    #1;
    occ = exp_q.size();
    chk("out_val_occupancy", out_val, occ != 0);
    if (out_val && out_rdy && occ != 0) begin
      h = exp_q.pop_front();
      chk("out_beat", {out_data, out_sop, out_eop, out_mod, out_err}, h);
      pops++;
    end
    if (pkt_rx_val && pkt_rx_eop) chk("ren_low_on_eop", pkt_rx_ren, 0);
    if (occ + int'(ren_prev) >= 4) chk("ren_no_room", pkt_rx_ren, 0);
    if (pkt_rx_val && ren_prev) begin
      chk("push_not_full", occ < 4, 1);
      b = '{data: pkt_rx_data, sop: pkt_rx_sop | !in_frame, eop: pkt_rx_eop, mod: pkt_rx_mod, err: pkt_rx_err};
      exp_q.push_back(b);
      in_frame = !pkt_rx_eop;
      pushed++;
    end
    ren_prev = pkt_rx_ren;
    @(posedge clk); #1;
  endtask
  task automatic drain();
    int k;
    for (k = 0; k < 3000; k++) begin
      if (mac_q.size() == 0 && exp_q.size() == 0 && !ren_prev && !pkt_rx_val) break;
      step();
    end
    if (k == 3000) chk("drain_timeout", 0, 1);
  endtask
  task automatic chk_stats(input string tag);
    chk({tag, "_frame_cnt"}, frame_cnt, 32'(e_frames));
    chk({tag, "_byte_cnt"}, byte_cnt, 32'(e_bytes));
    chk({tag, "_err_cnt"}, err_cnt, 32'(e_err));
    chk({tag, "_proto_err_cnt"}, proto_err_cnt, 32'(e_proto));
    chk({tag, "_last_frame_len"}, last_frame_len, 16'(e_last));
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ren"}, pkt_rx_ren, 0);
    chk({tag, "_out_val"}, out_val, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_byte_cnt"}, byte_cnt, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_proto_err_cnt"}, proto_err_cnt, 0);
    chk({tag, "_last_frame_len"}, last_frame_len, 0);
  endtask
  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1;
    @(posedge clk); #1;
    // 64-byte frame
    add_frame(8, 0, 0, 1);
    drain();
    chk_stats("t1");
    // 61-byte frame
    add_frame(8, 5, 0, 1);
    drain();
    chk_stats("t2");
    // 16-beat frame, downstream stalls after two beats
    add_frame(16, 0, 0, 1);
    pops = 0; pushed = 0;
    for (k = 0; k < 200 && pops < 2; k++) step();
    out_rdy = 0;
    repeat (20) step();
    chk("t3_stall_pushed", pushed, 6);
    out_rdy = 1;
    drain();
    chk("t3_total_pushed", pushed, 16);
    chk_stats("t3");
    // errored frame then clean frame
    add_frame(3, 0, 1, 1);
    add_frame(2, 3, 0, 1);
    drain();
    chk_stats("t4");
    // stray beat, frame without sop, sop inside a frame
    stray_req = 1;
    e_proto++;
    repeat (3) step();
    chk("t5_stray_proto", proto_err_cnt, 32'(e_proto));
    add_frame(2, 1, 0, 0);
    add_partial(3);
    add_frame(4, 2, 0, 1);
    drain();
    chk_stats("t5");
    // randomized frames and downstream backpressure, including single-beat frames
    rand_rdy = 1;
    for (int f = 0; f < 8; f++)
      add_frame($urandom_range(1, 12), $urandom_range(0, 7), $urandom_range(0, 1) == 1, 1);
    drain();
    rand_rdy = 0;
    out_rdy = 1;
    chk_stats("rand");
    // reset in the middle of a frame
    add_frame(8, 0, 0, 1);
    pushed = 0;
    for (k = 0; k < 100 && pushed < 3; k++) step();
    pkt_rx_val = 0;
    rst_n = 0;
    #1;
    chk_zero("midreset");
    mac_q.delete(); exp_q.delete();
    ren_prev = 0; in_frame = 0;
    e_frames = 0; e_bytes = 0; e_err = 0; e_proto = 0; e_last = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    add_frame(5, 6, 1, 1);
    drain();
    chk_stats("t6");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/xgemac_rx_pkt_reader.md
Name: xgemac_rx_pkt_reader

Overview:
- User-side reader of the XGEMAC receive packet interface, the counterpart of the TX packet source.
- Waits for pkt_rx_avail, drives pkt_rx_ren, and captures returned beats (data/val/sop/eop/mod/err) into a small skid FIFO.
- Presents frames on a valid/ready stream to downstream logic and keeps frame, byte, error and protocol-error statistics.

Parameters:
- DATA_WIDTH, 64, packet data width in bits (8 bytes per beat).
- MOD_WIDTH, 3, byte-modulus width; 0 means all 8 bytes valid.
- FIFO_DEPTH, 4, skid FIFO entries; power of two, minimum 2.
- CNT_WIDTH, 32, statistics counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, active low.
- pkt_rx_ren  out  1  read enable to MAC.
- pkt_rx_avail  in  1  MAC has at least one frame queued.
- pkt_rx_data  in  DATA_WIDTH  rx beat data.
- pkt_rx_val  in  1  beat valid; returned one cycle after ren.
- pkt_rx_sop  in  1  first beat of frame.
- pkt_rx_eop  in  1  last beat of frame.
- pkt_rx_mod  in  MOD_WIDTH  valid bytes on eop beat.
- pkt_rx_err  in  1  frame error, qualified on eop.
- out_data  out  DATA_WIDTH  downstream data.
- out_val  out  1  downstream beat valid.
- out_sop / out_eop / out_err  out  1 each  frame markers.
- out_mod  out  MOD_WIDTH  byte modulus.
- out_rdy  in  1  downstream accepts beat.
- frame_cnt  out  CNT_WIDTH  frames completed (eop pushed).
- byte_cnt  out  CNT_WIDTH  bytes pushed.
- err_cnt  out  CNT_WIDTH  frames with err on eop.
- proto_err_cnt  out  CNT_WIDTH  protocol violations.
- last_frame_len  out  16  byte length of last completed frame.

Behaviour:
- Single clock clk; reset rst_n is asynchronous, active-low.
- Reset clears all outputs, counters, FIFO and FSM: ren=0, out_val=0, counters=0, last_frame_len=0, FSM=IDLE.
- FSM states:
  - IDLE -> READ when pkt_rx_avail=1.
  - READ -> IDLE on the cycle an accepted beat has val&eop.
- ren_q is a register holding last cycle's pkt_rx_ren (one read in flight).
- pkt_rx_ren is combinational = (state==READ) & (fifo_count + ren_q < FIFO_DEPTH) & !(pkt_rx_val & pkt_rx_eop). It is never asserted in the eop cycle, so the MAC cannot start the next frame early.
- Beat accepted when pkt_rx_val=1 and ren_q=1; it is pushed to the FIFO the same edge.
- Protocol-error cases (proto_err_cnt +1 each):
  - val with ren_q=0: beat dropped.
  - First beat of a frame without sop: beat pushed with out_sop forced to 1.
  - sop while already in frame: new frame starts; previous frame length is discarded and the previous frame is not counted.
- Byte arithmetic: beat bytes = 8 unless eop & mod!=0, then mod. Frame length accumulator is 16 bits and saturates at 0xFFFF. On eop it is copied to last_frame_len.
- Counter updates on the eop push:
  - frame_cnt +1.
  - err_cnt +1 if err.
- byte_cnt adds every pushed beat's bytes.
- All counters wrap modulo 2^CNT_WIDTH.
- FIFO behaviour:
  - First-word fall-through; out_* reflect the head entry; pop on out_val&out_rdy.
  - Push and pop in the same cycle is legal at any fill level, including full.
  - Push while full cannot occur by construction; the bench asserts this.
- Latency: MAC beat at edge N is visible on out_* after edge N (1 cycle) when the FIFO was empty.
- pkt_rx_avail deasserting in READ mid-frame is ignored; reading continues until eop.

Decomposition:
- Shared package xgemac_pkg holds:
  - DATA_WIDTH/MOD_WIDTH constants.
  - rx_state_e enum (IDLE, READ).
  - rx_beat_t packed struct {data, sop, eop, mod, err}.
  - function beat_bytes(eop, mod).
- One sub-module: xgemac_rx_skid_fifo (rx_beat_t storage, push/pop, count, full/empty).

Test Plan:
1. 64-byte frame (8 beats, mod=0 on eop), out_rdy=1 -> 8 out beats in order, sop on beat 0, eop on beat 7; frame_cnt=1, byte_cnt=64, last_frame_len=64; ren low on eop cycle.
2. 61-byte frame (8 beats, eop mod=5) -> last out beat mod=5; byte_cnt=61, last_frame_len=61.
3. 16-beat frame with out_rdy=0 from beat 2 on -> ren drops once count+ren_q=4; no beat lost or duplicated; after out_rdy=1 all 16 beats delivered in order.
4. Frame with err=1 on eop, then clean frame -> err_cnt=1, frame_cnt=2, out_err=1 on first eop only.
5. pkt_rx_val pulse while ren_q=0 -> no out_val, proto_err_cnt=1; then sop mid-frame -> proto_err_cnt=2, frame_cnt unchanged until next eop.
6. rst_n low mid-frame (beat 3 of 8) -> next cycle ren=0, out_val=0, all counters 0; after release with avail=1, a fresh frame is read correctly.
